lr35902_snd_pulse: RTL and testbench

//  Square-wave voice generator (voices 1 and 2) feeding the sound mixer/PWM stage.

---
 rtl/lr35902_snd_pulse_pkg.sv | 52 +++++
 rtl/lr35902_snd_env.sv | 56 +++++
 rtl/lr35902_snd_pulse.sv | 199 +++++++++++++++++++
 tb/tb_lr35902_snd_pulse.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lr35902_snd_pulse_pkg.sv
// Shared definitions for the square-wave voices: field widths, register
// addresses, duty pattern table and the sweep adder.
package lr35902_snd_pulse_pkg;

    localparam int FREQ_W = 11;
    localparam int LEN_W  = 7;
    localparam int VOL_W  = 4;
    localparam int ENV_W  = 3;

    localparam logic [LEN_W-1:0] LEN_MAX = 7'd64;

    // Sound register addresses (low byte of 0xFF1x / 0xFF2x)
    localparam logic [7:0] NR10_ADDR = 8'h10;
    localparam logic [7:0] NR11_ADDR = 8'h11;
    localparam logic [7:0] NR12_ADDR = 8'h12;
    localparam logic [7:0] NR13_ADDR = 8'h13;
    localparam logic [7:0] NR14_ADDR = 8'h14;
    localparam logic [7:0] NR21_ADDR = 8'h16;
    localparam logic [7:0] NR22_ADDR = 8'h17;
    localparam logic [7:0] NR23_ADDR = 8'h18;
    localparam logic [7:0] NR24_ADDR = 8'h19;
    localparam logic [7:0] NR52_ADDR = 8'h26;

    typedef enum logic [1:0] {
        DUTY_12P5 = 2'd0,
        DUTY_25   = 2'd1,
        DUTY_50   = 2'd2,
        DUTY_75   = 2'd3
    } duty_e;

    // Waveform bit for a given duty setting and step (bit index = step)
    function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
        logic [7:0] pat;
        case (duty)
            DUTY_12P5: pat = 8'b0000_0001;
            DUTY_25:   pat = 8'b1000_0001;
            DUTY_50:   pat = 8'b1000_0111;
            default:   pat = 8'b0111_1110;
        endcase
        return pat[step];
    endfunction

    // Sweep step: sh +- (sh >> shift), 12 bits so bit 11 flags an add overflow
    function automatic logic [FREQ_W:0] swp_calc(input logic [FREQ_W-1:0] sh,
                                                input logic dec,
                                                input logic [2:0] shift);
        logic [FREQ_W:0] d;
        d = {1'b0, sh >> shift};
        return dec ? ({1'b0, sh} - d) : ({1'b0, sh} + d);
    endfunction

endpackage

// File: rtl/lr35902_snd_env.sv
// Volume envelope: loads on trigger, steps the volume up/down by one every
// vol_time envelope ticks, saturating at 0 and 15. Shared with the noise voice.
module lr35902_snd_env
    import lr35902_snd_pulse_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             trigger,
    input  logic             tick_env,
    input  logic [VOL_W-1:0] vol_init,
    input  logic             vol_inc,
    input  logic [ENV_W-1:0] vol_time,
    output logic [VOL_W-1:0] vol
);

    logic [VOL_W-1:0] vol_q, vol_d;
    logic [ENV_W-1:0] tmr_q, tmr_d;

    // Next volume / envelope timer; trigger beats a coincident tick
    always_comb begin
        vol_d = vol_q;
        tmr_d = tmr_q;
        if (clr) begin
            vol_d = '0;
            tmr_d = '0;
        end else if (trigger) begin
            vol_d = vol_init;
            tmr_d = vol_time;
        end else if (tick_env && vol_time != 3'd0) begin
            if (tmr_q <= 3'd1) begin
                tmr_d = vol_time;
                if (vol_inc && vol_q != 4'd15)
                    vol_d = vol_q + 4'd1;
                else if (!vol_inc && vol_q != 4'd0)
                    vol_d = vol_q - 4'd1;
            end else begin
                tmr_d = tmr_q - 3'd1;
            end
        end
    end

    // Envelope state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vol_q <= '0;
            tmr_q <= '0;
        end else begin
            vol_q <= vol_d;
            tmr_q <= tmr_d;
        end
    end

    assign vol = vol_q;

endmodule

// File: rtl/lr35902_snd_pulse.sv
// Square-wave voice (1 with sweep, 2 without): frequency timer, duty
// sequencer, length counter, envelope and optional frequency sweep.
module lr35902_snd_pulse
    import lr35902_snd_pulse_pkg::*;
#(
    parameter int SWEEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        master_ena,
    input  logic        ftick,
    input  logic        tick_len,
    input  logic        tick_swp,
    input  logic        tick_env,
    input  logic        trigger,
    input  logic        len_wr,
    input  logic [5:0]  len_val,
    input  logic [1:0]  duty,
    input  logic        cntlen,
    input  logic [10:0] freq,
    input  logic [3:0]  vol_init,
    input  logic        vol_inc,
    input  logic [2:0]  vol_time,
    input  logic [2:0]  swp_time,
    input  logic        swp_dec,
    input  logic [2:0]  swp_shift,
    output logic [3:0]  amp,
    output logic        active,
    output logic        freq_wb,
    output logic [10:0] freq_wb_val
);

    logic [FREQ_W-1:0] timer_q, timer_d;
    logic [2:0]        step_q, step_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              active_q, active_d;
    logic [VOL_W-1:0]  amp_q, amp_d;
    logic [FREQ_W-1:0] shadow_q, shadow_d;
    logic [3:0]        swp_tmr_q, swp_tmr_d;
    logic              swp_en_q, swp_en_d;
    logic              freq_wb_q, freq_wb_d;
    logic [FREQ_W-1:0] freq_wb_val_q, freq_wb_val_d;

    logic [VOL_W-1:0]  vol;
    logic              dac_on;
    logic [FREQ_W-1:0] reload;
    logic [3:0]        swp_reload;
    logic [LEN_W-1:0]  len_nx;
    logic [FREQ_W:0]   calc_trig, calc_a, calc_b;
    logic              ovf_trig, ovf_a, ovf_b;

    assign dac_on     = (vol_init != 4'd0) | vol_inc;
    // 0 - freq in 11 bits is 2048 - freq; freq=0 gives 0, which wraps to a
    // full 2048-tick period because expiry is detected at 1.
    assign reload     = 11'd0 - freq;
    assign swp_reload = (swp_time == 3'd0) ? 4'd8 : {1'b0, swp_time};
    assign len_nx     = len_wr ? (LEN_MAX - {1'b0, len_val}) : len_q;

    // Sweep adders: trigger-time check, tick calc, and the follow-up check
    assign calc_trig = swp_calc(freq, swp_dec, swp_shift);
    assign calc_a    = swp_calc(shadow_q, swp_dec, swp_shift);
    assign calc_b    = swp_calc(calc_a[FREQ_W-1:0], swp_dec, swp_shift);
    assign ovf_trig  = !swp_dec && calc_trig[FREQ_W];
    assign ovf_a     = !swp_dec && calc_a[FREQ_W];
    assign ovf_b     = !swp_dec && calc_b[FREQ_W];

    lr35902_snd_env u_env (
        .clk      (clk),
        .reset    (reset),
        .clr      (!master_ena),
        .trigger  (trigger),
        .tick_env (tick_env),
        .vol_init (vol_init),
        .vol_inc  (vol_inc),
        .vol_time (vol_time),
        .vol      (vol)
    );

    // Channel next-state: timer/step, length, sweep, active flag, sample
    always_comb begin
        timer_d       = timer_q;
        step_d        = step_q;
        len_d         = len_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        swp_tmr_d     = swp_tmr_q;
        swp_en_d      = swp_en_q;
        freq_wb_d     = 1'b0;
        freq_wb_val_d = freq_wb_val_q;

        // Frequency timer; trigger reloads without touching the step
        if (trigger) begin
            timer_d = reload;
        end else if (ftick) begin
            if (timer_q == 11'd1) begin
                timer_d = reload;
                step_d  = step_q + 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end

        // Length counter; a written length is applied before trigger's 0->64 rule
        if (trigger) begin
            len_d = (len_nx == 7'd0) ? LEN_MAX : len_nx;
        end else begin
            len_d = len_nx;
            if (tick_len && cntlen && len_nx != 7'd0) begin
                len_d = len_nx - 7'd1;
                if (len_nx == 7'd1)
                    active_d = 1'b0;
            end
        end

        if (trigger)
            active_d = dac_on;

        // Frequency sweep
        if (SWEEP != 0) begin
            if (trigger) begin
                shadow_d  = freq;
                swp_tmr_d = swp_reload;
                swp_en_d  = (swp_time != 3'd0) || (swp_shift != 3'd0);
                if (swp_shift != 3'd0 && ovf_trig)
                    active_d = 1'b0;
            end else if (tick_swp && swp_en_q) begin
                if (swp_tmr_q <= 4'd1) begin
                    swp_tmr_d = swp_reload;
                    if (swp_time != 3'd0) begin
                        if (ovf_a) begin
                            active_d = 1'b0;
                        end else if (swp_shift != 3'd0) begin
                            shadow_d      = calc_a[FREQ_W-1:0];
                            freq_wb_d     = 1'b1;
                            freq_wb_val_d = calc_a[FREQ_W-1:0];
                            if (ovf_b)
                                active_d = 1'b0;
                        end
                    end
                end else begin
                    swp_tmr_d = swp_tmr_q - 4'd1;
                end
            end
        end

        // DAC off forces the channel inactive regardless of anything above
        if (!dac_on)
            active_d = 1'b0;

        // Sample uses registered step/volume, so it trails them by one cycle
        amp_d = (active_q && duty_bit(duty, step_q)) ? vol : 4'd0;

        if (!master_ena) begin
            timer_d       = '0;
            step_d        = '0;
            len_d         = '0;
            active_d      = 1'b0;
            amp_d         = '0;
            shadow_d      = '0;
            swp_tmr_d     = '0;
            swp_en_d      = 1'b0;
            freq_wb_d     = 1'b0;
            freq_wb_val_d = '0;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q       <= '0;
            step_q        <= '0;
            len_q         <= '0;
            active_q      <= 1'b0;
            amp_q         <= '0;
            shadow_q      <= '0;
            swp_tmr_q     <= '0;
            swp_en_q      <= 1'b0;
            freq_wb_q     <= 1'b0;
            freq_wb_val_q <= '0;
        end else begin
            timer_q       <= timer_d;
            step_q        <= step_d;
            len_q         <= len_d;
            active_q      <= active_d;
            amp_q         <= amp_d;
            shadow_q      <= shadow_d;
            swp_tmr_q     <= swp_tmr_d;
            swp_en_q      <= swp_en_d;
            freq_wb_q     <= freq_wb_d;
            freq_wb_val_q <= freq_wb_val_d;
        end
    end

    assign amp         = amp_q;
    assign active      = active_q;
    assign freq_wb     = freq_wb_q;
    assign freq_wb_val = freq_wb_val_q;

endmodule

// File: tb/tb_lr35902_snd_pulse.sv
// Directed bench for the square-wave voice: per-cycle vector table plus
// hand sequences for the duty waveform and the reset/master-enable clears.
module tb_lr35902_snd_pulse;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        master_ena = 1'b0;
    logic        ftick = 1'b0, tick_len = 1'b0, tick_swp = 1'b0, tick_env = 1'b0;
    logic        trigger = 1'b0, len_wr = 1'b0;
    logic [5:0]  len_val = '0;
    logic [1:0]  duty = '0;
    logic        cntlen = 1'b0;
    logic [10:0] freq = '0;
    logic [3:0]  vol_init = '0;
    logic        vol_inc = 1'b0;
    logic [2:0]  vol_time = '0;
    logic [2:0]  swp_time = '0;
    logic        swp_dec = 1'b0;
    logic [2:0]  swp_shift = '0;
    logic [3:0]  amp;
    logic        active;
    logic        freq_wb;
    logic [10:0] freq_wb_val;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lr35902_snd_pulse #(.SWEEP(1)) dut (
        .clk(clk), .reset(reset), .master_ena(master_ena), .ftick(ftick),
        .tick_len(tick_len), .tick_swp(tick_swp), .tick_env(tick_env),
        .trigger(trigger), .len_wr(len_wr), .len_val(len_val), .duty(duty),
        .cntlen(cntlen), .freq(freq), .vol_init(vol_init), .vol_inc(vol_inc),
        .vol_time(vol_time), .swp_time(swp_time), .swp_dec(swp_dec),
        .swp_shift(swp_shift), .amp(amp), .active(active), .freq_wb(freq_wb),
        .freq_wb_val(freq_wb_val)
    );

    typedef struct {
        logic [1:0]  duty;
        logic [10:0] freq;
        logic [3:0]  vi;
        logic        inc;
        logic [2:0]  vt;
        logic [5:0]  lv;
        logic        cl;
        logic [2:0]  st;
        logic        sd;
        logic [2:0]  ss;
    } cfg_t;

    typedef struct {
        int          cfg;
        logic        m, tr, tl, ts, te, lw;
        logic [3:0]  e_amp;
        logic        e_act, e_wb;
        logic [10:0] e_wbv;
    } vec_t;

    cfg_t cf[10];
    vec_t vt[40];

    function automatic cfg_t C(int d, int f, int vi, int inc, int vtm, int lv,
                               int cl, int st, int sd, int ss);
        cfg_t c;
        c.duty = 2'(d); c.freq = 11'(f); c.vi = 4'(vi); c.inc = 1'(inc);
        c.vt = 3'(vtm); c.lv = 6'(lv); c.cl = 1'(cl); c.st = 3'(st);
        c.sd = 1'(sd); c.ss = 3'(ss);
        return c;
    endfunction

    function automatic vec_t V(int c, int m, int tr, int tl, int ts, int te, int lw,
                               int ea, int eact, int ewb, int ewbv);
        vec_t v;
        v.cfg = c; v.m = 1'(m); v.tr = 1'(tr); v.tl = 1'(tl); v.ts = 1'(ts);
        v.te = 1'(te); v.lw = 1'(lw); v.e_amp = 4'(ea); v.e_act = 1'(eact);
        v.e_wb = 1'(ewb); v.e_wbv = 11'(ewbv);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        duty = c.duty; freq = c.freq; vol_init = c.vi; vol_inc = c.inc;
        vol_time = c.vt; len_val = c.lv; cntlen = c.cl; swp_time = c.st;
        swp_dec = c.sd; swp_shift = c.ss;
    endtask

    initial begin
        logic [7:0] p2;
        p2 = 8'b1000_0111;

        cf[0] = C(2, 0,    15, 0, 0, 62, 1, 0, 0, 0);
        cf[1] = C(2, 0,    15, 0, 0, 62, 0, 0, 0, 0);
        cf[2] = C(2, 0,    15, 0, 0, 63, 1, 0, 0, 0);
        cf[3] = C(2, 0,    2,  0, 1, 0,  0, 0, 0, 0);
        cf[4] = C(2, 0,    14, 1, 1, 0,  0, 0, 0, 0);
        cf[5] = C(2, 0,    0,  0, 0, 0,  0, 0, 0, 0);
        cf[6] = C(2, 1024, 15, 0, 0, 0,  0, 1, 0, 1);
        cf[7] = C(2, 1024, 15, 0, 0, 0,  0, 1, 1, 2);
        cf[8] = C(2, 1400, 15, 0, 0, 0,  0, 0, 0, 1);
        cf[9] = C(2, 2047, 15, 0, 0, 0,  0, 0, 0, 0);

        //           cfg m tr tl ts te lw  amp act wb wbv
        // length counter, cntlen on/off, trigger dropping a tick
        vt[0]  = V(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[1]  = V(0, 1, 1, 0, 0, 0, 1,  0, 1, 0, 0);
        vt[2]  = V(0, 1, 0, 0, 0, 0, 0, 15, 1, 0, 0);
        vt[3]  = V(0, 1, 0, 1, 0, 0, 0, 15, 1, 0, 0);
        vt[4]  = V(0, 1, 0, 1, 0, 0, 0, 15, 0, 0, 0);
        vt[5]  = V(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[6]  = V(1, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vt[7]  = V(1, 1, 0, 1, 0, 0, 0, 15, 1, 0, 0);
        vt[8]  = V(1, 1, 0, 1, 0, 0, 0, 15, 1, 0, 0);
        vt[9]  = V(2, 1, 0, 0, 0, 0, 1, 15, 1, 0, 0);
        vt[10] = V(2, 1, 1, 1, 0, 0, 0, 15, 1, 0, 0);
        vt[11] = V(2, 1, 0, 1, 0, 0, 0, 15, 0, 0, 0);
        // envelope down to 0 and up to saturation
        vt[12] = V(3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[13] = V(3, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vt[14] = V(3, 1, 0, 0, 0, 0, 0,  2, 1, 0, 0);
        vt[15] = V(3, 1, 0, 0, 0, 1, 0,  2, 1, 0, 0);
        vt[16] = V(3, 1, 0, 0, 0, 1, 0,  1, 1, 0, 0);
        vt[17] = V(3, 1, 0, 0, 0, 1, 0,  0, 1, 0, 0);
        vt[18] = V(3, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        vt[19] = V(4, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vt[20] = V(4, 1, 0, 0, 0, 1, 0, 14, 1, 0, 0);
        vt[21] = V(4, 1, 0, 0, 0, 1, 0, 15, 1, 0, 0);
        vt[22] = V(4, 1, 0, 0, 0, 0, 0, 15, 1, 0, 0);
        // DAC off: trigger ignored, and DAC turned off while playing
        vt[23] = V(5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[24] = V(5, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[25] = V(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[26] = V(3, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vt[27] = V(5, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0);
        vt[28] = V(5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        // sweep: add with follow-up overflow, decrement, trigger overflow
        vt[29] = V(6, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        vt[30] = V(6, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0);
        vt[31] = V(6, 1, 0, 0, 1, 0, 0, 15, 0, 1, 1536);
        vt[32] = V(6, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1536);
        vt[33] = V(7, 1, 1, 0, 0, 0, 0,  0, 1, 0, 1536);
        vt[34] = V(7, 1, 0, 0, 1, 0, 0, 15, 1, 1, 768);
        vt[35] = V(7, 1, 0, 0, 1, 0, 0, 15, 1, 1, 576);
        vt[36] = V(7, 1, 0, 0, 0, 0, 0, 15, 1, 0, 576);
        vt[37] = V(8, 1, 1, 0, 0, 0, 0, 15, 0, 0, 576);
        vt[38] = V(7, 1, 1, 0, 1, 0, 0,  0, 1, 0, 576);
        vt[39] = V(7, 1, 0, 0, 1, 0, 0, 15, 1, 1, 768);

        // async reset state
        #2;
        chk("reset_amp", 16'(amp), 16'd0);
        chk("reset_active", 16'(active), 16'd0);
        chk("reset_wb", 16'(freq_wb), 16'd0);
        chk("reset_wbv", 16'(freq_wb_val), 16'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            apply_cfg(cf[vt[i].cfg]);
            master_ena = vt[i].m; trigger = vt[i].tr; tick_len = vt[i].tl;
            tick_swp = vt[i].ts; tick_env = vt[i].te; len_wr = vt[i].lw;
            @(posedge clk);
            #1;
            trigger = 1'b0; tick_len = 1'b0; tick_swp = 1'b0; tick_env = 1'b0; len_wr = 1'b0;
            chk($sformatf("v%0d_amp", i), 16'(amp), 16'(vt[i].e_amp));
            chk($sformatf("v%0d_active", i), 16'(active), 16'(vt[i].e_act));
            chk($sformatf("v%0d_wb", i), 16'(freq_wb), 16'(vt[i].e_wb));
            chk($sformatf("v%0d_wbv", i), 16'(freq_wb_val), 16'(vt[i].e_wbv));
        end

        // duty 2 waveform at freq 2047 with ftick every cycle
        @(negedge clk);
        apply_cfg(cf[9]);
        master_ena = 1'b0;
        @(negedge clk);
        master_ena = 1'b1; trigger = 1'b1; ftick = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        chk("duty_trig_active", 16'(active), 16'd1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("duty_amp_%0d", k), 16'(amp), p2[(k - 1) % 8] ? 16'd15 : 16'd0);
        end

        // async reset mid-tone clears outputs without a clock edge
        @(negedge clk);
        chk("pre_reset_active", 16'(active), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_amp", 16'(amp), 16'd0);
        chk("async_active", 16'(active), 16'd0);
        chk("async_wb", 16'(freq_wb), 16'd0);
        @(negedge clk);
        reset = 1'b1;

        // master_ena low mid-tone clears on the next clock
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_mena_active", 16'(active), 16'd1);
        master_ena = 1'b0;
        #1;
        chk("mena_before_edge", 16'(active), 16'd1);
        @(posedge clk);
        #1;
        chk("mena_active", 16'(active), 16'd0);
        chk("mena_amp", 16'(amp), 16'd0);
        // trigger ignored while master_ena is low
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0; ftick = 1'b0;
        chk("mena_trig_ignored", 16'(active), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
